instruction_loader: RTL and testbench

//  Boot-time program loader directly upstream of instruction_memory.
//  - Consumes a byte stream from the UART receiver: 4-byte word-count header,

---
 rtl/mips_defs.sv | 21 ++
 rtl/instruction_loader_if.sv | 24 ++
 rtl/byte_assembler.sv | 42 ++++
 rtl/instruction_loader.sv | 132 +++++++++++++
 tb/tb_instruction_loader.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the boot loader: state encoding, word geometry and
// the instruction-memory address width.
package mips_defs;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        LOAD   = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int IMEM_ADDR_W    = 16;

    function automatic logic is_last_byte(input logic [BYTE_CNT_W-1:0] cnt);
        return cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte stream in, memory write port and status out. The UART side is the
// master; the loader is the slave.
interface instruction_loader_if;

    logic                                 rx_valid;
    logic [7:0]                           rx_data;
    logic                                 write_enable;
    logic [mips_defs::IMEM_ADDR_W-1:0]    address;
    logic [31:0]                          write_data;
    logic                                 busy;
    logic                                 cpu_run;
    logic                                 error;

    modport master (
        output rx_valid, rx_data,
        input  write_enable, address, write_data, busy, cpu_run, error
    );

    modport slave (
        input  rx_valid, rx_data,
        output write_enable, address, write_data, busy, cpu_run, error
    );

endinterface

// File: rtl/byte_assembler.sv
// Packs a big-endian byte stream into words. word/word_ready are combinational
// so the completed word is usable in the same cycle its last byte arrives.
module byte_assembler
    import mips_defs::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic [WORD_W-1:0]     word,
    output logic                  word_ready
);

    // Only the earlier bytes need storage; the newest lane comes straight from the input.
    logic [WORD_W-9:0]     shift_reg;
    logic [BYTE_CNT_W-1:0] cnt_reg;

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi == 0) begin : g_new
                assign word[7:0] = byte_data;
            end else begin : g_old
                assign word[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    assign word_ready = byte_valid && is_last_byte(cnt_reg);
    assign byte_cnt   = cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else if (byte_valid) begin
            cnt_reg   <= cnt_reg + BYTE_CNT_W'(1);
            shift_reg <= word[WORD_W-9:0];
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Boot-time loader: reads a word-count header and that many instruction words
// from the UART byte stream, writes them to instruction memory, then releases the CPU.
module instruction_loader
    import mips_defs::*;
#(
    parameter int MEM_SIZE       = 20000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_loader_if.slave  bus
);

    localparam logic [31:0] MEM_LIMIT    = 32'(MEM_SIZE);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    loader_state_t          state_reg, state_next;
    logic [31:0]            count_reg, count_next;
    logic [31:0]            word_cnt_reg, word_cnt_next;
    logic [31:0]            timer_reg, timer_next;
    logic [31:0]            write_data_reg, write_data_next;
    logic [IMEM_ADDR_W-1:0] address_reg, address_next;
    logic                   write_enable_reg, write_enable_next;
    logic                   busy_reg, busy_next;
    logic                   cpu_run_reg, cpu_run_next;
    logic                   error_reg, error_next;

    logic                   accepting;
    logic                   byte_valid;
    logic                   mid_word_idle;
    logic                   timeout;
    logic [BYTE_CNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0]      assembled_word;
    logic                   word_ready;

    // DONE and ERROR ignore the stream entirely, so the assembler never sees those bytes.
    assign accepting     = (state_reg == HEADER) || (state_reg == LOAD);
    assign byte_valid    = accepting && bus.rx_valid;
    assign mid_word_idle = accepting && (byte_cnt != '0) && !bus.rx_valid;
    assign timeout       = mid_word_idle && (timer_reg == TIMEOUT_LAST);

    byte_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (bus.rx_data),
        .byte_cnt   (byte_cnt),
        .word       (assembled_word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        word_cnt_next     = word_cnt_reg;
        write_data_next   = write_data_reg;
        address_next      = address_reg;
        write_enable_next = 1'b0;
        timer_next        = mid_word_idle ? timer_reg + 32'd1 : 32'd0;

        case (state_reg)
            HEADER: begin
                if (word_ready) begin
                    count_next = assembled_word;
                    if (assembled_word == 32'd0)
                        state_next = DONE;
                    else if (assembled_word > MEM_LIMIT)
                        state_next = ERROR;
                    else
                        state_next = LOAD;
                end else if (timeout) begin
                    state_next = ERROR;
                end
            end
            LOAD: begin
                // Pulse ends: advance to the next word slot, finish after the last one.
                if (write_enable_reg) begin
                    word_cnt_next = word_cnt_reg + 32'd1;
                    address_next  = word_cnt_next[IMEM_ADDR_W-1:0];
                    if (word_cnt_next == count_reg)
                        state_next = DONE;
                end
                if (word_ready) begin
                    write_data_next   = assembled_word;
                    write_enable_next = 1'b1;
                end else if (timeout) begin
                    state_next = ERROR;
                end
            end
            default: begin
            end
        endcase

        busy_next    = (state_next == HEADER) || (state_next == LOAD);
        cpu_run_next = (state_next == DONE);
        error_next   = (state_next == ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= HEADER;
            count_reg        <= '0;
            word_cnt_reg     <= '0;
            timer_reg        <= '0;
            write_data_reg   <= '0;
            address_reg      <= '0;
            write_enable_reg <= 1'b0;
            busy_reg         <= 1'b1;
            cpu_run_reg      <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            word_cnt_reg     <= word_cnt_next;
            timer_reg        <= timer_next;
            write_data_reg   <= write_data_next;
            address_reg      <= address_next;
            write_enable_reg <= write_enable_next;
            busy_reg         <= busy_next;
            cpu_run_reg      <= cpu_run_next;
            error_reg        <= error_next;
        end
    end

    assign bus.write_enable = write_enable_reg;
    assign bus.address      = address_reg;
    assign bus.write_data   = write_data_reg;
    assign bus.busy         = busy_reg;
    assign bus.cpu_run      = cpu_run_reg;
    assign bus.error        = error_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a table of whole-load vectors plus
// hand-written sequences for latency, timeout, mid-load reset and gapped input.
module tb_instruction_loader;
    import mips_defs::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instruction_loader_if bus ();

    instruction_loader #(
        .MEM_SIZE       (20000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] header;
        logic [31:0] w0;
        logic [31:0] w1;
        int          n_send;
        int          exp_writes;
        logic        exp_run;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t tbl [7];

    int n_vec = 0;
    int n_bad = 0;
    int double_pulses = 0;
    logic we_prev = 1'b0;
    logic [15:0] wr_addr [$];
    logic [31:0] wr_data [$];

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.write_enable) begin
            wr_addr.push_back(bus.address);
            wr_data.push_back(bus.write_data);
            if (we_prev) double_pulses++;
        end
        we_prev = bus.write_enable;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        idle(2);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " write_enable"}, 32'(bus.write_enable), 32'd0);
        check({tag, " address"},      32'(bus.address),      32'd0);
        check({tag, " write_data"},   bus.write_data,        32'd0);
        check({tag, " busy"},         32'(bus.busy),         32'd1);
        check({tag, " cpu_run"},      32'(bus.cpu_run),      32'd0);
        check({tag, " error"},        32'(bus.error),        32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        //            header        w0            w1            send writes run busy err
        tbl[0] = '{32'h00000002, 32'h8C010004, 32'h00221820, 2, 2, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{32'h00000000, 32'h11111111, 32'h22222222, 0, 0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{32'h00004E21, 32'h33333333, 32'h44444444, 1, 0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{32'h00004E20, 32'h55667788, 32'h00000000, 1, 1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'h00000001, 32'hDEADBEEF, 32'h00000000, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFFFFFF, 32'h01020304, 32'h00000000, 1, 0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{32'h00000003, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 2, 1'b0, 1'b1, 1'b0};

        do_reset();
        check_reset_values("reset");

        for (int i = 0; i < 7; i++) begin
            do_reset();
            send_word(tbl[i].header);
            for (int j = 0; j < tbl[i].n_send; j++)
                send_word(j == 0 ? tbl[i].w0 : tbl[i].w1);
            idle(3);
            $display("vec %0d header=%h writes=%0d run=%b busy=%b err=%b",
                     i, tbl[i].header, wr_addr.size(), bus.cpu_run, bus.busy, bus.error);
            check($sformatf("vec%0d writes", i), 32'(wr_addr.size()), 32'(tbl[i].exp_writes));
            for (int j = 0; j < tbl[i].exp_writes && j < wr_addr.size(); j++) begin
                check($sformatf("vec%0d addr%0d", i, j), 32'(wr_addr[j]), 32'(j));
                check($sformatf("vec%0d data%0d", i, j), wr_data[j], j == 0 ? tbl[i].w0 : tbl[i].w1);
            end
            check($sformatf("vec%0d cpu_run", i), 32'(bus.cpu_run), 32'(tbl[i].exp_run));
            check($sformatf("vec%0d busy", i),    32'(bus.busy),    32'(tbl[i].exp_busy));
            check($sformatf("vec%0d error", i),   32'(bus.error),   32'(tbl[i].exp_err));
        end

        // Latency: last byte at edge k -> pulse during k..k+1, release right after.
        do_reset();
        send_word(32'h00000001);
        send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h04);
        $display("latency: we=%b addr=%h data=%h", bus.write_enable, bus.address, bus.write_data);
        check("lat pulse we",   32'(bus.write_enable), 32'd1);
        check("lat pulse addr", 32'(bus.address),      32'd0);
        check("lat pulse data", bus.write_data,        32'h8C010004);
        check("lat pulse run",  32'(bus.cpu_run),      32'd0);
        idle(1);
        check("lat after we",   32'(bus.write_enable), 32'd0);
        check("lat after addr", 32'(bus.address),      32'd1);
        check("lat after run",  32'(bus.cpu_run),      32'd1);
        check("lat after busy", 32'(bus.busy),         32'd0);

        // Timeout: error exactly 16 cycles after the last byte of a partial word.
        do_reset();
        send_word(32'h00000001);
        send_byte(8'hAA); send_byte(8'hBB);
        idle(15);
        check("timeout early error", 32'(bus.error), 32'd0);
        idle(1);
        $display("timeout: error=%b busy=%b writes=%0d", bus.error, bus.busy, wr_addr.size());
        check("timeout error",  32'(bus.error),        32'd1);
        check("timeout busy",   32'(bus.busy),         32'd0);
        check("timeout writes", 32'(wr_addr.size()),   32'd0);

        // Reset mid-load, including mid-word, then a fresh single-word load.
        do_reset();
        send_word(32'h00000003);
        send_word(32'h11223344);
        send_byte(8'h55);
        idle(1);
        check("midreset writes before", 32'(wr_addr.size()), 32'd1);
        do_reset();
        check_reset_values("midreset");
        send_word(32'h00000001);
        send_word(32'hDEADBEEF);
        idle(2);
        $display("midreset reload: writes=%0d run=%b", wr_addr.size(), bus.cpu_run);
        check("reload writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) begin
            check("reload addr", 32'(wr_addr[0]), 32'd0);
            check("reload data", wr_data[0],      32'hDEADBEEF);
        end
        check("reload run", 32'(bus.cpu_run), 32'd1);

        // Long gaps between complete words must not time out; DONE ignores bytes.
        do_reset();
        send_word(32'h00000002);
        idle(50);
        send_word(32'h0BADF00D);
        idle(50);
        send_word(32'h12345678);
        idle(50);
        $display("gaps: writes=%0d run=%b err=%b", wr_addr.size(), bus.cpu_run, bus.error);
        check("gaps error",  32'(bus.error),      32'd0);
        check("gaps run",    32'(bus.cpu_run),    32'd1);
        check("gaps writes", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("gaps data0", wr_data[0],      32'h0BADF00D);
            check("gaps addr1", 32'(wr_addr[1]), 32'd1);
            check("gaps data1", wr_data[1],      32'h12345678);
        end
        send_word(32'hCAFEF00D);
        idle(3);
        check("done ignores writes", 32'(wr_addr.size()), 32'd2);
        check("done ignores run",    32'(bus.cpu_run),    32'd1);

        check("single-cycle pulses", 32'(double_pulses), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
